// File: rtl/moller_stream_pkg.sv
// Shared types and helpers for the ADC stream packetizer.
// Pure declarations, no logic and no latency.
// Has no flow control of its own; users of these types handle backpressure.
package moller_stream_pkg;

    localparam logic [7:0] PKT_ID_DEF = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        HDR0,
        HDR1,
        SMP,
        WAIT
    } pkt_state_e;

    // First header word of every packet
    typedef struct packed {
        logic [7:0]  id;
        logic [7:0]  nsel;
        logic [15:0] n;
        logic [15:0] seq;
        logic [8:0]  pad;
        logic [6:0]  rd;
    } hdr0_t;

    function automatic logic [31:0] sext18to32(input logic [17:0] v);
        return {{14{v[17]}}, v};
    endfunction

endpackage

// File: rtl/stream_fifo_sync.sv
// Synchronous show-ahead FIFO with a registered output word and a free-space count.
// Latency: a word written on one edge is presented on rd_dat after the next edge.
// Backpressure: the output word is held while rd_vld && !rd_rdy; the writer must respect free.
module stream_fifo_sync #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_vld,
    input  logic [WIDTH-1:0]         wr_dat,
    input  logic                     rd_rdy,
    output logic                     rd_vld,
    output logic [WIDTH-1:0]         rd_dat,
    output logic [$clog2(DEPTH):0]   free
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             load;

    // Refill the output register whenever it is empty or being consumed
    always_comb begin
        load = (cnt != '0) && (!rd_vld || rd_rdy);
        free = CW'(DEPTH) - cnt - CW'(rd_vld);
    end

    // Storage array: written without reset, contents qualified by cnt
    always_ff @(posedge clk) begin
        if (wr_vld) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    // Pointers, occupancy and the show-ahead output register
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            rd_vld <= 1'b0;
            rd_dat <= '0;
        end else begin
            if (wr_vld) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (load) begin
                rd_ptr <= rd_ptr + AW'(1);
                rd_dat <= mem[rd_ptr];
                rd_vld <= 1'b1;
            end else if (rd_rdy) begin
                rd_vld <= 1'b0;
            end
            cnt <= cnt + CW'(wr_vld) - CW'(load);
        end
    end

endmodule

// File: rtl/adc_stream_packetizer.sv
// Decimates multi-channel ADC samples and frames them into headered 64-bit stream packets.
// Latency: taken sample to HDR0 on m_tdata in 2 clk with an empty FIFO.
// Backpressure: m_tready stalls the FIFO; packets that do not fit are dropped whole at start.
module adc_stream_packetizer
    import moller_stream_pkg::*;
#(
    parameter int         NUM_CH     = 16,
    parameter int         NUM_SEL    = 4,
    parameter int         CH_SEL_W   = 4,
    parameter int         FIFO_DEPTH = 1024,
    parameter logic [7:0] PKT_ID     = PKT_ID_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ena,
    input  logic                         block,
    input  logic                         clear_counters,
    input  logic [NUM_SEL*CH_SEL_W-1:0]  ch_sel,
    input  logic [15:0]                  num_samples,
    input  logic [6:0]                   rate_div,
    input  logic                         in_valid,
    input  logic [NUM_CH*18-1:0]         in_data,
    input  logic [63:0]                  in_ts,
    output logic [63:0]                  m_tdata,
    output logic                         m_tvalid,
    output logic                         m_tlast,
    input  logic                         m_tready,
    output logic [15:0]                  drop_pkt_count,
    output logic [15:0]                  drop_sample_count,
    output logic                         busy
);
    localparam int              HALF    = NUM_SEL / 2;
    localparam int              K_W     = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int              FREE_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int              N_MAX   = (FIFO_DEPTH - 2) * 2 / NUM_SEL;
    localparam logic [K_W-1:0]  K_LAST  = K_W'(HALF - 1);
    localparam logic [31:0]     HALF_U  = 32'(HALF);
    localparam logic [31:0]     N_MAX_U = 32'(N_MAX);

    pkt_state_e state;
    pkt_state_e state_nxt;

    logic [6:0]                  dcnt;
    logic [6:0]                  rd_q;
    logic [6:0]                  rd_cur;
    logic                        taken;
    logic [NUM_SEL*CH_SEL_W-1:0] sel_q;
    logic [NUM_SEL*CH_SEL_W-1:0] sel_cur;
    logic [15:0]                 n_q;
    logic [15:0]                 n_req;
    logic [15:0]                 n_eff;
    logic [15:0]                 scnt;
    logic [15:0]                 seq;
    logic [31:0]                 nw;
    logic                        fits;
    logic [63:0]                 ts_q;
    logic [NUM_SEL-1:0][17:0]    cap_q;
    logic [NUM_SEL-1:0][17:0]    cap_nxt;
    logic [K_W-1:0]              k_q;
    logic                        k_last;
    logic                        pkt_done;
    logic [17:0]                 smp_lo;
    logic [17:0]                 smp_hi;
    hdr0_t                       hdr0;

    logic                        start;
    logic                        cap_en;
    logic                        pkt_drop;
    logic                        smp_drop;
    logic                        wr_vld;
    logic                        wr_last;
    logic [63:0]                 wr_dat;
    logic [FREE_W-1:0]           free;
    logic [64:0]                 rd_dat;

    // Decimation match, admission check, channel selection and word assembly
    always_comb begin
        rd_cur  = (state == IDLE) ? rate_div : rd_q;
        taken   = in_valid && (dcnt == rd_cur);
        sel_cur = (state == IDLE) ? ch_sel : sel_q;

        n_req = (num_samples == 16'd0) ? 16'd1 : num_samples;
        n_eff = (32'(n_req) > N_MAX_U) ? N_MAX_U[15:0] : n_req;
        nw    = 32'd2 + 32'(n_eff) * HALF_U;
        fits  = 32'(free) >= nw;

        // Out-of-range channel indices match nothing and read as zero
        for (int s = 0; s < NUM_SEL; s++) begin
            cap_nxt[s] = '0;
            for (int c = 0; c < NUM_CH; c++) begin
                if (sel_cur[s*CH_SEL_W +: CH_SEL_W] == CH_SEL_W'(c)) begin
                    cap_nxt[s] = in_data[c*18 +: 18];
                end
            end
        end

        smp_lo = '0;
        smp_hi = '0;
        for (int j = 0; j < HALF; j++) begin
            if (k_q == K_W'(j)) begin
                smp_lo = cap_q[2*j];
                smp_hi = cap_q[2*j+1];
            end
        end

        hdr0.id   = PKT_ID;
        hdr0.nsel = 8'(NUM_SEL);
        hdr0.n    = n_q;
        hdr0.seq  = seq;
        hdr0.pad  = '0;
        hdr0.rd   = rd_q;

        k_last   = (k_q == K_LAST);
        pkt_done = (scnt == n_q - 16'd1);
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state and per-cycle FIFO write / event strobes
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        cap_en    = 1'b0;
        pkt_drop  = 1'b0;
        smp_drop  = 1'b0;
        wr_vld    = 1'b0;
        wr_last   = 1'b0;
        wr_dat    = '0;
        case (state)
            IDLE: begin
                if (taken && ena && !block) begin
                    if (fits) begin
                        start     = 1'b1;
                        cap_en    = 1'b1;
                        state_nxt = HDR0;
                    end else begin
                        pkt_drop = 1'b1;
                    end
                end
            end
            HDR0: begin
                wr_vld    = 1'b1;
                wr_dat    = hdr0;
                smp_drop  = taken;
                state_nxt = HDR1;
            end
            HDR1: begin
                wr_vld    = 1'b1;
                wr_dat    = ts_q;
                smp_drop  = taken;
                state_nxt = SMP;
            end
            SMP: begin
                wr_vld   = 1'b1;
                wr_dat   = {sext18to32(smp_hi), sext18to32(smp_lo)};
                wr_last  = k_last && pkt_done;
                smp_drop = taken;
                if (k_last) begin
                    state_nxt = pkt_done ? IDLE : WAIT;
                end
            end
            WAIT: begin
                if (taken) begin
                    cap_en    = 1'b1;
                    state_nxt = SMP;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Decimator, latched per-packet configuration and packet progress
    always_ff @(posedge clk) begin
        if (rst) begin
            dcnt  <= '0;
            rd_q  <= '0;
            sel_q <= '0;
            n_q   <= 16'd1;
            ts_q  <= '0;
            cap_q <= '0;
            k_q   <= '0;
            scnt  <= '0;
            seq   <= '0;
        end else begin
            if (start) begin
                dcnt <= '0;
            end else if (in_valid) begin
                dcnt <= taken ? 7'd0 : dcnt + 7'd1;
            end
            if (start) begin
                rd_q  <= rate_div;
                sel_q <= ch_sel;
                n_q   <= n_eff;
                ts_q  <= in_ts;
                scnt  <= '0;
                k_q   <= '0;
            end
            if (cap_en) begin
                cap_q <= cap_nxt;
            end
            if (state == HDR0) begin
                seq <= seq + 16'd1;
            end
            if (state == SMP) begin
                k_q <= k_last ? '0 : k_q + K_W'(1);
                if (k_last && !pkt_done) begin
                    scnt <= scnt + 16'd1;
                end
            end
        end
    end

    // Saturating drop counters; clear beats a same-cycle increment
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_pkt_count    <= '0;
            drop_sample_count <= '0;
        end else begin
            if (clear_counters) begin
                drop_pkt_count <= '0;
            end else if (pkt_drop && drop_pkt_count != 16'hFFFF) begin
                drop_pkt_count <= drop_pkt_count + 16'd1;
            end
            if (clear_counters) begin
                drop_sample_count <= '0;
            end else if (smp_drop && drop_sample_count != 16'hFFFF) begin
                drop_sample_count <= drop_sample_count + 16'd1;
            end
        end
    end

    stream_fifo_sync #(
        .WIDTH (65),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_vld (wr_vld),
        .wr_dat ({wr_last, wr_dat}),
        .rd_rdy (m_tready),
        .rd_vld (m_tvalid),
        .rd_dat (rd_dat),
        .free   (free)
    );

    assign m_tdata = rd_dat[63:0];
    assign m_tlast = rd_dat[64];
    assign busy    = (state != IDLE);

endmodule

// File: tb/tb_adc_stream_packetizer.sv
// Directed bench for adc_stream_packetizer with a stream scoreboard.
// Expected words are queued as samples are driven and compared as they leave the DUT.
// A small FIFO (16 words) and 12 channels exercise admission, clamping and out-of-range selects.
module tb_adc_stream_packetizer;
    localparam int NCH   = 12;
    localparam int NSEL  = 4;
    localparam int SW    = 4;
    localparam int DEPTH = 16;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  ena;
    logic                  block;
    logic                  clear_counters;
    logic [NSEL*SW-1:0]    ch_sel;
    logic [15:0]           num_samples;
    logic [6:0]            rate_div;
    logic                  in_valid;
    logic [NCH*18-1:0]     in_data;
    logic [63:0]           in_ts;
    logic [63:0]           m_tdata;
    logic                  m_tvalid;
    logic                  m_tlast;
    logic                  m_tready;
    logic [15:0]           drop_pkt_count;
    logic [15:0]           drop_sample_count;
    logic                  busy;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [64:0] sb [$];
    logic [64:0] mon_exp;
    logic [17:0] chv [NCH];
    logic [63:0] ts_ctr  = 64'h1000_0000_0000_0000;
    logic [15:0] exp_seq = 16'd0;

    adc_stream_packetizer #(
        .NUM_CH     (NCH),
        .NUM_SEL    (NSEL),
        .CH_SEL_W   (SW),
        .FIFO_DEPTH (DEPTH),
        .PKT_ID     (8'hA5)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .ena               (ena),
        .block             (block),
        .clear_counters    (clear_counters),
        .ch_sel            (ch_sel),
        .num_samples       (num_samples),
        .rate_div          (rate_div),
        .in_valid          (in_valid),
        .in_data           (in_data),
        .in_ts             (in_ts),
        .m_tdata           (m_tdata),
        .m_tvalid          (m_tvalid),
        .m_tlast           (m_tlast),
        .m_tready          (m_tready),
        .drop_pkt_count    (drop_pkt_count),
        .drop_sample_count (drop_sample_count),
        .busy              (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected 32-bit slot value from the bench's own channel table
    function automatic logic [31:0] slot_val(input int s);
        int idx;
        idx = int'(ch_sel[s*SW +: SW]);
        if (idx >= NCH) return 32'd0;
        return {{14{chv[idx][17]}}, chv[idx]};
    endfunction

    task automatic push_hdr(input logic [15:0] n, input logic [6:0] rd);
        sb.push_back({1'b0, 8'hA5, 8'd4, n, exp_seq, 9'd0, rd});
        sb.push_back({1'b0, ts_ctr});
        exp_seq = exp_seq + 16'd1;
    endtask

    task automatic push_smp(input logic last);
        sb.push_back({1'b0, slot_val(1), slot_val(0)});
        sb.push_back({last, slot_val(3), slot_val(2)});
    endtask

    task automatic set_ch(input int base);
        for (int i = 0; i < NCH; i++) chv[i] = 18'(base + i * 1000);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One-cycle in_valid strobe; consecutive calls are spaced gap cycles apart
    task automatic drive_sample(input int gap);
        for (int i = 0; i < NCH; i++) in_data[i*18 +: 18] = chv[i];
        in_ts    = ts_ctr;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        ts_ctr   = ts_ctr + 64'd1;
        step(gap - 1);
    endtask

    task automatic wait_drain();
        int i;
        i = 0;
        while ((sb.size() != 0 || busy || m_tvalid) && i < 500) begin
            step(1);
            i++;
        end
        chk("drain", 65'(sb.size() == 0 && !busy && !m_tvalid), 65'd1);
    endtask

    // Stream monitor: every accepted word must match the scoreboard head
    always @(negedge clk) begin
        if (!rst && m_tvalid && m_tready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $error("FAIL stream_extra: observed %h with nothing expected", {m_tlast, m_tdata});
            end else begin
                mon_exp = sb.pop_front();
                chk("stream", {m_tlast, m_tdata}, mon_exp);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; ena = 1'b0; block = 1'b0; clear_counters = 1'b0;
        ch_sel = 16'h3210; num_samples = 16'd3; rate_div = 7'd0;
        in_valid = 1'b0; in_data = '0; in_ts = '0; m_tready = 1'b1;
        set_ch(0);
        step(3);
        rst = 1'b0;
        chk("rst_tvalid", 65'(m_tvalid), 65'd0);
        chk("rst_tlast", 65'(m_tlast), 65'd0);
        chk("rst_tdata", 65'(m_tdata), 65'd0);
        chk("rst_busy", 65'(busy), 65'd0);
        chk("rst_dpc", 65'(drop_pkt_count), 65'd0);
        chk("rst_dsc", 65'(drop_sample_count), 65'd0);

        // Test 1: basic packet, N=3, ch[i]=i*1000, latency of HDR0
        ena = 1'b1;
        push_hdr(16'd3, 7'd0);
        push_smp(1'b0);
        drive_sample(1);
        chk("t1_busy", 65'(busy), 65'd1);
        step(1);
        chk("t1_lat1_tvalid", 65'(m_tvalid), 65'd0);
        step(1);
        chk("t1_lat2_tvalid", 65'(m_tvalid), 65'd1);
        chk("t1_hdr0", 65'(m_tdata), 65'h0_A504_0003_0000_0000);
        step(3);
        set_ch(7);
        push_smp(1'b0);
        drive_sample(6);
        set_ch(13);
        push_smp(1'b1);
        drive_sample(6);
        wait_drain();

        // Test 2: rate_div=4, N=2, valid every 10 clk; decimator primed so the 1st test valid is taken
        rate_div = 7'd4;
        num_samples = 16'd2;
        ena = 1'b0;
        set_ch(20);
        repeat (4) drive_sample(10);
        ena = 1'b1;
        set_ch(21);
        push_hdr(16'd2, 7'd4);
        push_smp(1'b0);
        drive_sample(10);
        for (int v = 2; v <= 5; v++) begin
            set_ch(30 + v);
            drive_sample(10);
        end
        set_ch(50);
        push_smp(1'b1);
        drive_sample(10);
        wait_drain();

        // Test 3: most negative value, max positive value, out-of-range select, num_samples=0
        rate_div = 7'd0;
        num_samples = 16'd0;
        ch_sel = {4'd15, 4'd11, 4'd5, 4'd0};
        set_ch(0);
        chv[0] = 18'h20000;
        chv[5] = 18'h1FFFF;
        chv[11] = 18'd12345;
        push_hdr(16'd1, 7'd0);
        sb.push_back({1'b0, 64'h0001FFFF_FFFE0000});
        sb.push_back({1'b1, 64'h00000000_00003039});
        drive_sample(6);
        wait_drain();
        chk("t3_dsc", 65'(drop_sample_count), 65'd0);

        // Test 4: stalled sink, N=6 fills 14 of 16 words, second packet refused
        m_tready = 1'b0;
        num_samples = 16'd6;
        ch_sel = 16'h3210;
        set_ch(100);
        push_hdr(16'd6, 7'd0);
        push_smp(1'b0);
        drive_sample(6);
        for (int s = 1; s <= 5; s++) begin
            set_ch(100 + s);
            push_smp(s == 5);
            drive_sample(6);
        end
        step(2);
        set_ch(190);
        drive_sample(6);
        chk("t4_dpc", 65'(drop_pkt_count), 65'd1);
        chk("t4_busy", 65'(busy), 65'd0);
        chk("t4_tvalid", 65'(m_tvalid), 65'd1);
        chk("t4_hold_a", 65'(m_tdata), 65'h0_A504_0006_0003_0000);
        step(5);
        chk("t4_hold_b", 65'(m_tdata), 65'h0_A504_0006_0003_0000);
        m_tready = 1'b1;
        wait_drain();

        // Test 4b: num_samples too large for the FIFO is clamped to 7 (16 words)
        num_samples = 16'd100;
        set_ch(200);
        push_hdr(16'd7, 7'd0);
        push_smp(1'b0);
        drive_sample(6);
        for (int s = 1; s <= 6; s++) begin
            set_ch(200 + s);
            push_smp(s == 6);
            drive_sample(6);
        end
        wait_drain();
        chk("t4b_dpc", 65'(drop_pkt_count), 65'd1);

        // Test 5: clear counters, then samples every 2 clk; valids 0, 3, 5 land, 1, 2, 4, 6 dropped
        clear_counters = 1'b1;
        step(1);
        clear_counters = 1'b0;
        chk("t5_clear_dpc", 65'(drop_pkt_count), 65'd0);
        num_samples = 16'd3;
        for (int v = 0; v <= 6; v++) begin
            set_ch(300 + v * 7);
            if (v == 0) push_hdr(16'd3, 7'd0);
            if (v == 0 || v == 3 || v == 5) push_smp(v == 5);
            drive_sample(2);
        end
        wait_drain();
        chk("t5_dsc", 65'(drop_sample_count), 65'd4);
        chk("t5_dpc", 65'(drop_pkt_count), 65'd0);

        // Test 6a: ena/block dropped mid-packet do not truncate it; block stops a new start
        num_samples = 16'd2;
        set_ch(400);
        push_hdr(16'd2, 7'd0);
        push_smp(1'b0);
        drive_sample(6);
        ena = 1'b0;
        block = 1'b1;
        set_ch(410);
        push_smp(1'b1);
        drive_sample(6);
        wait_drain();
        ena = 1'b1;
        set_ch(420);
        drive_sample(6);
        chk("t6_block_busy", 65'(busy), 65'd0);
        step(5);
        block = 1'b0;

        // Test 6b: reset mid-packet clears outputs and FIFO, seq restarts at 0
        m_tready = 1'b0;
        set_ch(500);
        drive_sample(1);
        step(3);
        chk("t6_pre_rst_tvalid", 65'(m_tvalid), 65'd1);
        rst = 1'b1;
        step(1);
        chk("t6_rst_tvalid", 65'(m_tvalid), 65'd0);
        chk("t6_rst_tdata", 65'(m_tdata), 65'd0);
        chk("t6_rst_tlast", 65'(m_tlast), 65'd0);
        chk("t6_rst_busy", 65'(busy), 65'd0);
        chk("t6_rst_dsc", 65'(drop_sample_count), 65'd0);
        rst = 1'b0;
        sb.delete();
        exp_seq = 16'd0;
        m_tready = 1'b1;
        step(2);
        chk("t6_fifo_empty", 65'(m_tvalid), 65'd0);
        num_samples = 16'd1;
        set_ch(600);
        push_hdr(16'd1, 7'd0);
        push_smp(1'b1);
        drive_sample(6);
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
